// File: rtl/mod_arith_pkg.sv
// Shared constants and state encoding for the modular-exponentiation sequencer.
//   N   : operand / exponent width
//   CW  : width of the exponent bit-index counter
//   P   : field prime 2^255-19
//   ONE : multiplicative identity at operand width
package mod_arith_pkg;

  localparam int unsigned N  = 255;
  localparam int unsigned CW = $clog2(N);

  localparam logic [N-1:0] P   = {{(N-8){1'b1}}, 8'hED};
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_X = 3'd1,
    ST_WAIT_X  = 3'd2,
    ST_ISSUE_S = 3'd3,
    ST_WAIT_S  = 3'd4,
    ST_FIN     = 3'd5
  } ladder_state_t;

endpackage

// File: rtl/ladder_sel.sv
// Montgomery-ladder operand select and writeback decode.
//   state_i   : current sequencer state
//   b_i       : exponent bit being processed
//   ack_i     : multiplier product valid
//   r0_i/r1_i : ladder registers
//   mul_a_c/mul_b_c : multiplier operands (zero outside a multiply)
//   we_r0_c/we_r1_c : load mul_p into R0 / R1 this cycle
module ladder_sel
  import mod_arith_pkg::*;
(
  input  ladder_state_t  state_i,
  input  logic           b_i,
  input  logic           ack_i,
  input  logic [N-1:0]   r0_i,
  input  logic [N-1:0]   r1_i,
  output logic [N-1:0]   mul_a_c,
  output logic [N-1:0]   mul_b_c,
  output logic           we_r0_c,
  output logic           we_r1_c
);

  // Cross product R0*R1 lands in the register selected by b; the square
  // uses the other register, which still holds its pre-step value.
  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    we_r0_c = 1'b0;
    we_r1_c = 1'b0;
    case (state_i)
      ST_ISSUE_X, ST_WAIT_X: begin
        mul_a_c = r0_i;
        mul_b_c = r1_i;
        if (state_i == ST_WAIT_X && ack_i) begin
          we_r0_c = b_i;
          we_r1_c = ~b_i;
        end
      end
      ST_ISSUE_S, ST_WAIT_S: begin
        mul_a_c = b_i ? r1_i : r0_i;
        mul_b_c = b_i ? r1_i : r0_i;
        if (state_i == ST_WAIT_S && ack_i) begin
          we_r0_c = ~b_i;
          we_r1_c = b_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Constant-time x^k mod p sequencer (Montgomery ladder, MSB-first) driving a
// shared external modular multiplier over a req/ack handshake.
//   clk, rst_n        : clock, async active-low reset
//   start, x, k       : operation request and operands (sampled when idle)
//   busy, done        : operation in flight / one-cycle completion pulse
//   result            : x^k mod p, held until overwritten by the next operation
//   mul_req/a/b       : multiply request and operands (stable until ack)
//   mul_ack, mul_p    : multiply completion and product
module mod_exp_ctrl
  import mod_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  k,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          mul_req,
  output logic [N-1:0]  mul_a,
  output logic [N-1:0]  mul_b,
  input  logic          mul_ack,
  input  logic [N-1:0]  mul_p
);

  ladder_state_t  state_q, state_d;
  logic [N-1:0]   r0_q, r0_d;
  logic [N-1:0]   r1_q, r1_d;
  logic [N-1:0]   k_q, k_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [N-1:0]   result_q, result_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           req_q, req_d;

  logic           bit_c;
  logic           we_r0_c, we_r1_c;

  assign bit_c = k_q[idx_q];

  ladder_sel u_sel (
    .state_i (state_q),
    .b_i     (bit_c),
    .ack_i   (mul_ack),
    .r0_i    (r0_q),
    .r1_i    (r1_q),
    .mul_a_c (mul_a),
    .mul_b_c (mul_b),
    .we_r0_c (we_r0_c),
    .we_r1_c (we_r1_c)
  );

  // Next-state, ladder update and registered-output decode.
  always_comb begin
    state_d  = state_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    k_d      = k_q;
    idx_d    = idx_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = k;
          r0_d    = ONE;
          r1_d    = x;
          idx_d   = CW'(N - 1);
          state_d = ST_ISSUE_X;
        end
      end
      ST_ISSUE_X: state_d = ST_WAIT_X;
      ST_WAIT_X: begin
        if (mul_ack) state_d = ST_ISSUE_S;
      end
      ST_ISSUE_S: state_d = ST_WAIT_S;
      ST_WAIT_S: begin
        if (mul_ack) begin
          if (idx_q == '0) begin
            // Capture the final R0 now so result is valid alongside done.
            result_d = we_r0_c ? mul_p : r0_q;
            state_d  = ST_FIN;
          end else begin
            idx_d   = CW'(idx_q - 1'b1);
            state_d = ST_ISSUE_X;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (we_r0_c) r0_d = mul_p;
    if (we_r1_c) r1_d = mul_p;

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    req_d  = (state_d == ST_ISSUE_X) || (state_d == ST_ISSUE_S);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      r0_q     <= '0;
      r1_q     <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign mul_req = req_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural mod_mul of latency L.
module tb_mod_exp_ctrl;
  import mod_arith_pkg::*;

  localparam int unsigned W2 = 2 * N + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  x, k;
  logic          busy, done;
  logic [N-1:0]  result;
  logic          mul_req;
  logic [N-1:0]  mul_a, mul_b;
  logic          mul_ack = 1'b0;
  logic [N-1:0]  mul_p = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mod_exp_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_p   (mul_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [W2-1:0] t;
    t = W2'(a) * W2'(b);
    return N'(t % W2'(P));
  endfunction

  // Reference: right-to-left square-and-multiply.
  function automatic logic [N-1:0] modexp(input logic [N-1:0] base, input logic [N-1:0] e);
    logic [N-1:0] r, s;
    r = ONE;
    s = mulmod(base, ONE);
    for (int i = 0; i < int'(N); i++) begin
      if (e[i]) r = mulmod(r, s);
      s = mulmod(s, s);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_word();
    return N'({$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Behavioural multiplier: ack exactly mul_lat cycles after req.
  int           mul_lat = 1;
  int           req_cnt = 0;
  bit           pend    = 1'b0;
  int           cnt     = 0;
  bit           stab_en = 1'b1;
  logic [N-1:0] la, lb, lp;

  always @(posedge clk) begin
    mul_ack <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        if (stab_en && rst_n) begin
          check("op_a_stable", mul_a, la);
          check("op_b_stable", mul_b, lb);
        end
        mul_ack <= 1'b1;
        mul_p   <= lp;
        pend     = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    if (mul_req && rst_n) begin
      req_cnt++;
      check("req_overlap", N'(pend), N'(0));
      la = mul_a;
      lb = mul_b;
      lp = mulmod(mul_a, mul_b);
      if (mul_lat == 1) begin
        mul_ack <= 1'b1;
        mul_p   <= lp;
      end else begin
        pend = 1'b1;
        cnt  = mul_lat - 1;
      end
    end
  end

  task automatic run_op(input string tag, input logic [N-1:0] xv, input logic [N-1:0] kv,
                        input logic [N-1:0] exp, input int lat, input int poke);
    int t0;
    int lim;
    mul_lat = lat;
    req_cnt = 0;
    lim     = 2 * int'(N) * (lat + 1) + 50;
    @(negedge clk);
    start = 1'b1;
    x     = xv;
    k     = kv;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    x     = rnd_word();
    k     = rnd_word();
    check({tag, "_busy"}, N'(busy), N'(1));
    forever begin
      @(negedge clk);
      if (done || (cyc - t0 >= lim)) break;
      start = (cyc - t0 == poke);
      if (start) begin
        x = rnd_word();
        k = rnd_word();
      end
    end
    start = 1'b0;
    check({tag, "_done"}, N'(done), N'(1));
    check({tag, "_latency"}, N'(cyc - t0), N'(2 * int'(N) * (lat + 1)));
    check({tag, "_result"}, result, exp);
    check({tag, "_reqs"}, N'(req_cnt), N'(2 * N));
    // A start coinciding with done must be dropped.
    start = 1'b1;
    x     = rnd_word();
    k     = rnd_word();
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after"}, N'(busy), N'(0));
    @(negedge clk);
    check({tag, "_still_idle"}, N'(busy | mul_req), N'(0));
    check({tag, "_held"}, result, exp);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] xv, kv, half;
    logic [N:0]   tmp;
    int           t0;
    int           saw;

    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    k     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_req", N'(mul_req), N'(0));
    check("rst_result", result, '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", N'(5), N'(12), N'(244140625), 1, -1);
    run_op("k0", N'(7), N'(0), N'(1), int'($urandom_range(1, 2)), -1);
    run_op("x0", N'(0), N'(5), N'(0), int'($urandom_range(1, 2)), -1);
    run_op("k1", N'(123), N'(1), N'(123), int'($urandom_range(1, 2)), -1);
    run_op("pm1", P - ONE, N'(2), ONE, 5, -1);

    tmp  = {1'b0, P} + (N + 1)'(1);
    half = N'(tmp >> 1);
    run_op("inv2", N'(2), P - N'(2), half, 1, -1);
    run_op("fermat", N'(2), P - ONE, ONE, 1, -1);

    xv = rnd_word();
    kv = rnd_word();
    run_op("busy_start", xv, kv, modexp(xv, kv), 2, 100);

    // Reset mid-operation with a multiply still in flight.
    mul_lat = 6;
    @(negedge clk);
    start = 1'b1;
    x     = rnd_word();
    k     = rnd_word();
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((cyc - t0 >= 300) && pend && (cnt >= 3)) break;
      @(negedge clk);
    end
    check("rst_pending", N'(pend), N'(1));
    stab_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_busy", N'(busy), N'(0));
    check("mid_rst_done", N'(done), N'(0));
    check("mid_rst_req", N'(mul_req), N'(0));
    check("mid_rst_result", result, '0);
    check("mid_rst_mul_a", mul_a, '0);
    check("mid_rst_mul_b", mul_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    saw   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw = saw | int'(done) | int'(busy) | int'(mul_req);
    end
    check("stale_ack_ignored", N'(saw), N'(0));
    stab_en = 1'b1;
    run_op("after_rst", N'(3), N'(4), N'(81), 1, -1);

    for (int i = 0; i < 4; i++) begin
      xv = rnd_word();
      kv = rnd_word();
      run_op($sformatf("rnd%0d", i), xv, kv, modexp(xv, kv), int'($urandom_range(1, 3)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Sequencer for constant-time modular exponentiation result = x^k mod p (p = 2^255-19) using the Montgomery ladder.
- Owns the ladder registers R0/R1 and scans exponent bits MSB-first.
- Issues every multiply to a single shared external modular multiplier over a req/ack handshake.
- Sits between the scalar-op front end (start/done) and the mod_mul datapath.

Parameters:
N, 255, operand and exponent width in bits
CW, $clog2(N), width of bit-index counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
start  in  1  request; accepted only when busy=0
x  in  N  base, sampled on accepted start
k  in  N  exponent, sampled on accepted start
busy  out  1  high from cycle after accepted start through done cycle
done  out  1  one-cycle pulse, result valid
result  out  N  x^k mod p, held until next accepted start
mul_req  out  1  one-cycle pulse: mul_a/mul_b valid
mul_a  out  N  multiplier operand A, stable from req until ack
mul_b  out  N  multiplier operand B, stable from req until ack
mul_ack  in  1  one-cycle pulse: mul_p valid; arrives L>=1 cycles after mul_req
mul_p  in  N  product mul_a*mul_b mod p

Behaviour:
- Reset values:
  - busy=0, done=0, mul_req=0, result=0, mul_a=0, mul_b=0.
  - R0, R1, k_reg and bit counter all 0; state=IDLE.
- States: IDLE, ISSUE_X, WAIT_X, ISSUE_S, WAIT_S, FIN.
- IDLE, start=1 at cycle T:
  - Latch k_reg=k, R0=1, R1=x, idx=N-1.
  - Next state ISSUE_X.
- ISSUE_X (cross product):
  - mul_req=1, mul_a=R0, mul_b=R1.
  - Next state WAIT_X.
- WAIT_X:
  - Hold operands.
  - On mul_ack with b=k_reg[idx]: b=0 writes R1<=mul_p; b=1 writes R0<=mul_p.
  - Then go to ISSUE_S.
- ISSUE_S (square):
  - mul_req=1, with mul_a=mul_b set by b: b=0 uses R0, b=1 uses R1.
  - The operand is the register not written in WAIT_X, so it still holds the pre-step value.
- WAIT_S:
  - On mul_ack: b=0 writes R0<=mul_p; b=1 writes R1<=mul_p.
  - If idx==0 go to FIN; else idx<=idx-1 and go to ISSUE_X.
- FIN:
  - result<=R0, done=1 for one cycle, busy=0 next cycle.
  - Return to IDLE.
- Constant time:
  - Always exactly 2N multiplies, regardless of k or leading zeros.
  - No data-dependent state paths.
- Latency with multiplier latency L:
  - Each multiply costs L+1 cycles.
  - done asserted at cycle T+2N(L+1)+1.
  - Example: N=255, L=1 gives done at T+1021.
- Boundary conditions:
  - k=0: result=1. k=1: result=x.
  - x>=p: passed to the multiplier unreduced; reduction is the multiplier's responsibility.
  - start while busy=1: ignored; x and k are not resampled.
  - start in the same cycle as done: ignored; the next start is accepted in the following IDLE cycle.
  - mul_ack outside WAIT_X/WAIT_S, including a stale ack after reset: ignored.
  - mul_req never asserted while a multiply is outstanding.
  - Reset mid-operation: immediately returns to reset values. No done pulse; the partial result is discarded.

Decomposition:
- Shared package mod_arith_pkg holds:
  - field constant P = 2^255-19 and ONE = 1 (width N);
  - typedef enum ladder_state_t for the six states.
- One sub-module, ladder_sel:
  - combinational operand-select/writeback-enable from (state, b).
  - outputs mul_a, mul_b, we_r0, we_r1.
- mod_exp_ctrl keeps the FSM, counter and registers.

Test Plan:
Bench uses a behavioural mod_mul model with configurable L (product = a*b mod P, ack exactly L cycles after req).
1. x=5, k=12, L=1 -> result=244140625; done at T+1021; exactly 510 mul_req pulses.
2. k=0 with x=7 -> result=1. Separately, x=0, k=5 -> result=0. Separately, x=123, k=1 -> result=123.
3. x=P-1, k=2, L=5 -> result=1; done at T+3061.
4. x=2, k=P-2 -> result=(P+1)/2 (inverse of 2). Also x=2, k=P-1 -> result=1 (Fermat).
5. start pulsed with new x/k at T+100 while busy -> ignored; original result delivered, done at the original latency.
6. rst_n low at T+300 with a pending ack -> all outputs 0, ack ignored, no done. A fresh start after release (x=3, k=4) -> result=81.
